eth_tx_arbiter: RTL and testbench
=================================

// Module: eth_tx_arbiter
// PURPOSE
// - Shares one Ethernet TX MAC byte stream between NUM_REQ frame sources.
// - Grants whole frames round-robin, never splitting a frame.
// - Enforces an inter-frame gap (IFG) after every frame.
// - Truncates oversize frames. Sits between the frame builders and the MAC TX input.
// PARAMETERS
// - NUM_REQ     2     number of requesters, 2..8
// - DATA_W      8     stream data width, bits
// - IFG_CYCLES  12    idle cycles after each frame's last beat; 0 allowed
// - MAX_FRAME   1518  max beats per frame before forced truncation
// PORTS
// - clk       in   1               single clock, all logic rising-edge
// - rst       in   1               synchronous, active-low reset
// - s_valid   in   NUM_REQ         per-source beat valid
// - s_data    in   NUM_REQ*DATA_W  per-source data; source i at [i*DATA_W +: DATA_W]
// - s_last    in   NUM_REQ         per-source last beat of frame
// - s_ready   out  NUM_REQ         per-source accept
// - m_valid   out  1               to MAC: beat valid
// - m_data    out  DATA_W          to MAC: data
// - m_last    out  1               to MAC: last beat of frame
// - m_ready   in   1               MAC accept
// - m_abort   out  1               qualifies m_last: this frame was truncated
// - grant     out  NUM_REQ         one-hot owner; 0 when no owner
// - busy      out  1               state != IDLE
// BEHAVIOUR
// - Beat transfer: a beat transfers when valid && ready, on either side.
// - State machine: IDLE, XFER, DRAIN, IFG. Registered state, grant, rr_ptr, beat_cnt and ifg_cnt.
// - Reset (rst==0 at an edge) forces state=IDLE, grant=0, rr_ptr=0, beat_cnt=0 and ifg_cnt=0.
//   - Outputs then read m_valid=0, m_last=0, m_abort=0, s_ready=0, busy=0.
//   - Applies mid-frame too; the partial frame is abandoned without m_last.
// - IDLE -> XFER when any s_valid=1.
//   - Grant goes to the first requesting index searching upward from rr_ptr, with wrap.
//   - Grant is registered: the first beat can pass the cycle after the request is seen (1-cycle arbitration latency).
// - XFER: pass-through, zero latency, from the granted source g.
//   - m_valid=s_valid[g], m_data=s_data[g].
//   - s_ready[g]=m_ready; all other s_ready are 0.
//   - beat_cnt increments per transferred beat.
//   - Source idle mid-frame (s_valid[g]=0): hold XFER, m_valid=0, no timeout.
//   - Transfer with s_last[g]=1: m_last=1, m_abort=0; go to IFG with rr_ptr=g+1 mod NUM_REQ.
//   - Transfer of beat number MAX_FRAME with s_last[g]=0: force m_last=1 and m_abort=1 on that beat; go to DRAIN.
//   - Beat MAX_FRAME that carries s_last=1 is a normal end, no abort.
// - DRAIN: s_ready[g]=1 and m_valid=0.
//   - Source beats are discarded until s_last[g] transfers; then go to IFG with rr_ptr=g+1.
// - IFG: grant=0, all s_ready=0, m_valid=0.
//   - ifg_cnt counts IFG_CYCLES cycles, then IDLE.
//   - IFG_CYCLES=0: skip IFG and go straight to IDLE.
//   - Requests arriving during IFG wait; they are evaluated in IDLE.
// - Outside XFER, m_valid, m_last and m_abort are all 0.
// - beat_cnt width is clog2(MAX_FRAME+1); it clears on entry to XFER.
// - Source i held valid continuously is served within NUM_REQ-1 frames (starvation-free).
// STRUCTURE
// - eth_pkg holds:
//   - State encodings: ST_IDLE=2'b00, ST_XFER=2'b01, ST_DRAIN=2'b10, ST_IFG=2'b11.
//   - Defaults ETH_IFG_CYCLES=12 and ETH_MAX_FRAME=1518, shared with the MAC.
// - One sub-module: rr_pick, combinational.
//   - Inputs: req[NUM_REQ], ptr.
//   - Outputs: one-hot gnt, and any.
// - Top level holds the FSM, counters and output mux.
// TESTING
// - Lone source 1: 4-beat frame 0xA1..0xA4 -> grant=2'b10 one cycle after s_valid.
//   - m_data sequence A1..A4, m_last on A4.
//   - Then 12 cycles m_valid=0, busy=1, then busy=0.
// - Both sources valid continuously, 3-beat frames -> grants alternate 01,10,01,10.
//   - rr_ptr starts at 0 after reset; each frame is followed by 12-cycle IFG gaps.
// - MAX_FRAME=8, source 0 sends 11 beats -> beat 8 has m_last=1 and m_abort=1.
//   - Beats 9..11 are accepted (s_ready[0]=1) with m_valid=0.
//   - Then IFG.
// - m_ready toggles 1,0,1,0 during a 5-beat frame -> no beat lost or duplicated.
//   - s_ready[g] mirrors m_ready each cycle.
// - rst=0 asserted at beat 2 of a frame -> next cycle: grant=0, m_valid=0, busy=0.
//   - The next request is granted to source 0 first.
// - IFG_CYCLES=0, back-to-back frames from source 0 -> IDLE for one cycle.
//   - The next grant is in the following cycle.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: arbiter state encoding and the frame
// timing defaults used by both the arbiter and the MAC.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_XFER  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_IFG   = 2'b11
  } eth_state_e;

  localparam int ETH_IFG_CYCLES = 12;
  localparam int ETH_MAX_FRAME  = 1518;

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first set req bit at or above
// ptr, wrapping past the top index.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  logic found;

  // Outer loop walks priority order starting at ptr; inner loop maps it to a bit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Whole-frame round-robin arbiter in front of the MAC TX stream, with
// inter-frame gap insertion and oversize-frame truncation.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = 8,
  parameter int IFG_CYCLES = ETH_IFG_CYCLES,
  parameter int MAX_FRAME  = ETH_MAX_FRAME
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        s_valid,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic                      m_valid,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      m_abort,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int PTR_W    = $clog2(NUM_REQ);
  localparam int CNT_W    = $clog2(MAX_FRAME + 1);
  localparam int IFG_W    = $clog2(IFG_CYCLES + 2);
  localparam int IFG_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  eth_state_e state, state_n;
  logic [NUM_REQ-1:0] grant_n, pick_gnt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n, g, g_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
  logic [IFG_W-1:0]   ifg_cnt, ifg_cnt_n;
  logic               pick_any, trunc, frame_done;
  logic [NUM_REQ-1:0][DATA_W-1:0] s_data_v;

  assign s_data_v = s_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req (s_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) g = PTR_W'(i);
  end

  assign g_nxt  = (g == PTR_W'(NUM_REQ - 1)) ? '0 : g + PTR_W'(1);
  assign trunc  = (beat_cnt == CNT_W'(MAX_FRAME - 1));
  assign m_data = s_data_v[g];
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    ifg_cnt_n  = ifg_cnt;
    frame_done = 1'b0;
    s_ready    = '0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_abort    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n    = ST_XFER;
          grant_n    = pick_gnt;
          beat_cnt_n = '0;
        end
      end
      ST_XFER: begin
        s_ready[g] = m_ready;
        m_valid    = s_valid[g];
        if (s_valid[g]) begin
          m_last  = s_last[g] | trunc;
          m_abort = ~s_last[g] & trunc;
        end
        if (s_valid[g] && m_ready) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
          if (s_last[g])  frame_done = 1'b1;
          else if (trunc) state_n    = ST_DRAIN;
        end
      end
      // Truncated frame: swallow the remainder up to the source's own last beat.
      ST_DRAIN: begin
        s_ready[g] = 1'b1;
        if (s_valid[g] && s_last[g]) frame_done = 1'b1;
      end
      ST_IFG: begin
        if (ifg_cnt == IFG_W'(IFG_LAST)) state_n   = ST_IDLE;
        else                             ifg_cnt_n = ifg_cnt + IFG_W'(1);
      end
    endcase
    if (frame_done) begin
      grant_n   = '0;
      rr_ptr_n  = g_nxt;
      ifg_cnt_n = '0;
      if (IFG_CYCLES > 0) state_n = ST_IFG;
      else                state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      ifg_cnt  <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
      ifg_cnt  <= ifg_cnt_n;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: frame-level scoreboard driven by directed and
// randomized source/MAC behaviour, on an IFG=12 and an IFG=0 instance.
module tb_eth_tx_arbiter;

  localparam int NR  = 2;
  localparam int DW  = 8;
  localparam int MF  = 8;
  localparam int IFG = 12;

  logic clk, rst, m_ready, sel;
  logic [NR-1:0] s_valid, s_last;
  logic [NR*DW-1:0] s_data;

  logic [NR-1:0] s_ready_a, s_ready_b, grant_a, grant_b;
  logic m_valid_a, m_valid_b, m_last_a, m_last_b, m_abort_a, m_abort_b, busy_a, busy_b;
  logic [DW-1:0] m_data_a, m_data_b;

  logic [NR-1:0] o_s_ready, o_grant;
  logic o_m_valid, o_m_last, o_m_abort, o_busy;
  logic [DW-1:0] o_m_data;

  assign o_s_ready = sel ? s_ready_b : s_ready_a;
  assign o_grant   = sel ? grant_b   : grant_a;
  assign o_m_valid = sel ? m_valid_b : m_valid_a;
  assign o_m_last  = sel ? m_last_b  : m_last_a;
  assign o_m_abort = sel ? m_abort_b : m_abort_a;
  assign o_m_data  = sel ? m_data_b  : m_data_a;
  assign o_busy    = sel ? busy_b    : busy_a;

  eth_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .IFG_CYCLES(IFG), .MAX_FRAME(MF)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready_a), .m_valid(m_valid_a), .m_data(m_data_a), .m_last(m_last_a),
    .m_ready(m_ready), .m_abort(m_abort_a), .grant(grant_a), .busy(busy_a));

  eth_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .IFG_CYCLES(0), .MAX_FRAME(MF)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b),
    .m_ready(m_ready), .m_abort(m_abort_b), .grant(grant_b), .busy(busy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0, fails = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source frames still to send, and the beats the MAC should see from each source.
  int              len_q  [NR][$];
  logic [DW-1:0]   base_q [NR][$];
  logic [DW+1:0]   exp_q  [NR][$];
  int              bi     [NR];
  int              grant_log[$], start_log[$], end_log[$];
  int              cyc, vpct, rpct;
  bit              tog_mode, tog, chk_mirror;
  logic [NR-1:0]   prev_grant;

  task automatic add_frame(input int src, input int len, input logic [DW-1:0] base);
    len_q[src].push_back(len);
    base_q[src].push_back(base);
    for (int b = 0; b < len && b < MF; b++)
      exp_q[src].push_back({(b == MF - 1) && (len > MF), (b == len - 1) || (b == MF - 1),
                            DW'(base + b)});
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) begin
      len_q[i].delete(); base_q[i].delete(); exp_q[i].delete(); bi[i] = 0;
    end
    grant_log.delete(); start_log.delete(); end_log.delete();
    cyc = 0;
    prev_grant = '0;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NR; i++)
      if (len_q[i].size() > 0 || exp_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic step();
    int src, have;
    logic [DW+1:0] e;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (len_q[i].size() > 0 && $urandom_range(99) < vpct) begin
        s_valid[i] = 1'b1;
        s_data[i*DW +: DW] = DW'(base_q[i][0] + bi[i]);
        s_last[i] = (bi[i] == len_q[i][0] - 1);
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
      end
    end
    if (tog_mode) begin
      m_ready = tog;
      tog = !tog;
    end else begin
      m_ready = ($urandom_range(99) < rpct);
    end
    #1;
    chk("owner", ((o_s_ready & ~o_grant) == '0) && !(o_grant == '0 && o_m_valid), 1);
    if (chk_mirror && o_grant != '0) chk("mirror", (o_s_ready & o_grant) != '0, m_ready);
    src = -1;
    for (int i = 0; i < NR; i++) if (o_grant == (NR'(1) << i)) src = i;
    if (o_m_valid && m_ready) begin
      have = 0;
      if (src >= 0) have = exp_q[src].size();
      chk("beat_expected", have > 0, 1);
      if (have > 0) begin
        e = exp_q[src].pop_front();
        chk("beat", {o_m_abort, o_m_last, o_m_data}, e);
      end
    end
    if (o_grant != '0 && prev_grant == '0) begin
      grant_log.push_back(int'(o_grant));
      start_log.push_back(cyc);
    end
    prev_grant = o_grant;
    for (int i = 0; i < NR; i++) begin
      if (s_valid[i] && o_s_ready[i]) begin
        if (s_last[i]) begin
          void'(len_q[i].pop_front());
          void'(base_q[i].pop_front());
          bi[i] = 0;
          end_log.push_back(cyc);
        end else begin
          bi[i]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int budget, input string tag);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done"}, n < budget, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt, n;
    rst = 1'b0; sel = 1'b0; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
    vpct = 100; rpct = 100; tog_mode = 0; tog = 0; chk_mirror = 0;
    flush();

    // Reset state, with requests pending to show s_ready stays low.
    @(negedge clk); s_valid = '1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_last", m_last_a, 0);
    chk("rst_m_abort", m_abort_a, 0);
    chk("rst_s_ready", s_ready_a, 0);
    s_valid = '0;
    @(negedge clk); rst = 1'b1;

    // Lone source 1, 4-beat frame, then exactly IFG idle-busy cycles.
    flush();
    add_frame(1, 4, 8'hA1);
    run(50, "lone");
    chk("lone_grant", grant_log[0], 2);
    chk("lone_start", start_log[0], 1);
    chk("lone_end", end_log[0], 4);
    cnt = 0;
    repeat (IFG) begin
      step();
      if (o_busy && !o_m_valid && o_grant == '0) cnt++;
    end
    chk("lone_ifg", cnt, IFG);
    step();
    chk("lone_idle", o_busy, 0);

    // Both sources always valid: alternation from index 0, exact gaps.
    do_reset(); flush();
    add_frame(0, 3, 8'h10); add_frame(1, 3, 8'h20);
    add_frame(0, 3, 8'h30); add_frame(1, 3, 8'h40);
    run(200, "alt");
    for (int k = 0; k < 4; k++) chk("alt_grant", grant_log[k], (k % 2 == 0) ? 1 : 2);
    for (int k = 0; k < 3; k++) chk("alt_gap", start_log[k+1] - end_log[k], IFG + 2);

    // Oversize frame: 8 beats out with abort on the 8th, 3 more drained.
    flush();
    add_frame(0, 11, 8'h80);
    run(100, "trunc");
    chk("trunc_span", end_log[0] - start_log[0], 10);
    step();
    chk("trunc_ifg", o_busy && o_grant == '0 && !o_m_valid, 1);

    // MAC backpressure toggling every cycle.
    flush();
    tog_mode = 1; tog = 1; chk_mirror = 1;
    add_frame(1, 5, 8'h50);
    run(100, "toggle");
    tog_mode = 0; chk_mirror = 0;

    // Reset mid-frame after rr_ptr has moved to 1; next grant must go to 0.
    do_reset(); flush();
    add_frame(0, 2, 8'h01);
    run(100, "pre");
    flush();
    add_frame(1, 6, 8'h60);
    n = 0;
    while (exp_q[1].size() > 4 && n < 100) begin
      step();
      n++;
    end
    chk("mid_reached", exp_q[1].size(), 4);
    @(negedge clk); rst = 1'b0; s_valid = '0; s_last = '0;
    @(negedge clk); #1;
    chk("mid_rst_grant", o_grant, 0);
    chk("mid_rst_m_valid", o_m_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    rst = 1'b1;
    flush();
    add_frame(0, 2, 8'h70); add_frame(1, 2, 8'h71);
    run(100, "post");
    chk("post_first", grant_log[0], 1);

    // IFG_CYCLES=0 instance: one IDLE cycle between back-to-back frames.
    sel = 1'b1;
    do_reset(); flush();
    add_frame(0, 2, 8'h90); add_frame(0, 2, 8'hA0);
    run(100, "ifg0");
    chk("ifg0_gap", start_log[1] - end_log[0], 2);
    chk("ifg0_grant", grant_log[1], 1);

    // Randomized sources and MAC on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset(); flush();
      vpct = 70; rpct = 75;
      for (int f = 0; f < 30; f++)
        add_frame(f % NR, int'($urandom_range(1, 11)), DW'($urandom));
      run(20000, "rand");
      for (int k = 0; k + 1 < start_log.size() && k < end_log.size(); k++)
        chk("rand_gap", start_log[k+1] - end_log[k] >= (s == 0 ? IFG : 0) + 2, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
